// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle MIPS datapath.
// Word-organised unified instruction/data RAM answering one req/ready access at
// a time after LATENCY wait states. Optional misalignment checking is enabled
// by defining MEMRESP_ALIGN_CHECK_EN.
module mem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned IdxW   = $clog2(DEPTH);
    localparam logic [3:0]  LatCnt = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wd_q;
    logic [31:0] rd_q, rd_d;

    logic [31:0] mem [DEPTH];

    logic            accept, complete;
    logic            acc_we, acc_mis;
    logic [31:0]     acc_addr, acc_wd;
    logic [IdxW-1:0] acc_idx;

    // In IDLE the live inputs describe the access (needed when LATENCY=0 makes
    // the acceptance edge also the completion edge); otherwise the latched copy.
    assign accept   = (state_q == StIdle) && req;
    assign acc_we   = (state_q == StIdle) ? we   : we_q;
    assign acc_addr = (state_q == StIdle) ? addr : addr_q;
    assign acc_wd   = (state_q == StIdle) ? wd   : wd_q;
    assign acc_idx  = acc_addr[IdxW+1:2];
    assign complete = (accept && (LATENCY == 0)) || ((state_q == StWait) && (cnt_q == 4'd1));

    // Upper address bits wrap; byte-offset bits only matter to the align check.
    logic unused_addr;
    assign unused_addr = ^{acc_addr[31:IdxW+2], acc_addr[1:0]};

`ifdef MEMRESP_ALIGN_CHECK_EN
    logic mis_q;

    assign acc_mis = (state_q == StIdle) ? (addr[1:0] != 2'b00) : mis_q;

    // Remember whether the accepted access was misaligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= acc_mis;
        end
    end

    assign err = (state_q == StDone) && mis_q;
`else
    assign acc_mis = 1'b0;
    assign err     = 1'b0;
`endif

    // State, counter and read-data registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    // Capture request fields at acceptance so later input changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= 32'd0;
            wd_q   <= 32'd0;
        end else if (accept) begin
            we_q   <= we;
            addr_q <= addr;
            wd_q   <= wd;
        end
    end

    // Next-state, wait-state countdown and read data at completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                        cnt_d   = LatCnt;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (complete) begin
            if (acc_mis) begin
                rd_d = 32'd0;
            end else if (!acc_we) begin
                rd_d = mem[acc_idx];
            end
        end
    end

    // RAM write at the completion edge; contents survive reset, and a reset
    // coinciding with the edge must not commit the write
    always_ff @(posedge clk) begin
        if (complete && acc_we && !acc_mis && !reset) begin
            mem[acc_idx] <= acc_wd;
        end
    end

    assign rd    = rd_q;
    assign ready = (state_q == StDone);
    assign busy  = (state_q != StIdle);

endmodule
